// File: rtl/traffic_sensor_request.sv
// traffic_sensor_request: debounced per-road request generator and light monitor for a traffic light controller.
// Ports: clk, rstb (sync active-low); det_a_raw/det_b_raw raw detectors;
// light_x (A green), light_y (amber), light_z (B green) from the controller;
// req_a/req_b requests to the controller; wait_alarm_a/b long-wait flags; light_fault sticky illegal-light flag.
module traffic_sensor_request #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SERVE_CYCLES = 8,
  parameter int MAX_WAIT = 1000,
  parameter int WAIT_W = 10
) (
  input  logic clk,
  input  logic rstb,
  input  logic det_a_raw,
  input  logic det_b_raw,
  input  logic light_x,
  input  logic light_y,
  input  logic light_z,
  output logic req_a,
  output logic req_b,
  output logic wait_alarm_a,
  output logic wait_alarm_b,
  output logic light_fault
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SERVE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, PENDING, SERVING} state_t;
  logic [1:0] raw, green, req, alarm;
  logic [1:0] mcnt;
  logic fault;
  assign raw = {det_b_raw, det_a_raw};
  assign green = {light_z, light_x};
  assign {req_b, req_a} = req;
  assign {wait_alarm_b, wait_alarm_a} = alarm;
  for (genvar g = 0; g < 2; g++) begin : road
    logic s1, s2, deb, deb_q, alarm_r, rise;
    logic [DW-1:0] dcnt;
    logic [SW-1:0] scnt, scnt_n;
    logic [WAIT_W-1:0] wcnt, wcnt_n;
    state_t state, state_n;
    assign rise = deb & ~deb_q;
    assign req[g] = state != IDLE;
    assign alarm[g] = alarm_r;
    always_ff @(posedge clk) begin
      if (!rstb) begin
        {s1, s2, deb, deb_q, alarm_r} <= '0;
        dcnt <= '0;
        scnt <= '0;
        wcnt <= '0;
        state <= IDLE;
      end else begin
        s1 <= raw[g];
        s2 <= s1;
        deb_q <= deb;
        if (s2 == deb) dcnt <= '0;
        else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb <= ~deb;
          dcnt <= '0;
        end else dcnt <= dcnt + 1'b1;
        state <= state_n;
        scnt <= scnt_n;
        wcnt <= wcnt_n;
        alarm_r <= state_n == PENDING && wcnt_n == WAIT_W'(MAX_WAIT);
      end
    end
    // Retirement re-queues when the debounced level is still high; edges seen while busy are ignored.
    always_comb begin
      state_n = state;
      scnt_n = scnt;
      wcnt_n = wcnt;
      case (state)
        IDLE: if (rise) begin
          state_n = PENDING;
          wcnt_n = '0;
        end
        PENDING: if (green[g]) begin
          wcnt_n = '0;
          if (SERVE_CYCLES == 1) state_n = deb ? PENDING : IDLE;
          else begin
            state_n = SERVING;
            scnt_n = SW'(1);
          end
        end else if (wcnt != WAIT_W'(MAX_WAIT)) wcnt_n = wcnt + 1'b1;
        SERVING: if (!green[g]) begin
          state_n = PENDING;
          scnt_n = '0;
          wcnt_n = '0;
        end else if (scnt == SW'(SERVE_CYCLES - 1)) begin
          state_n = deb ? PENDING : IDLE;
          scnt_n = '0;
          wcnt_n = '0;
        end else scnt_n = scnt + 1'b1;
        default: state_n = IDLE;
      endcase
    end
  end
  assign fault = (light_x & light_z) | (light_y & (light_x | light_z)) | ~(light_x | light_y | light_z);
  // mcnt masks the light check for the first two cycles after reset release.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      mcnt <= '0;
      light_fault <= 1'b0;
    end else begin
      if (mcnt != 2'd2) mcnt <= mcnt + 1'b1;
      if (mcnt == 2'd2 && fault) light_fault <= 1'b1;
    end
  end
endmodule

// File: tb/tb_traffic_sensor_request.sv
// tb_traffic_sensor_request: directed self-checking bench for traffic_sensor_request.
module tb_traffic_sensor_request;
  logic clk = 1'b0;
  logic rstb, det_a_raw, det_b_raw, light_x, light_y, light_z;
  logic req_a, req_b, wait_alarm_a, wait_alarm_b, light_fault;
  int compared = 0;
  int mismatched = 0;
  traffic_sensor_request #(
    .DEBOUNCE_CYCLES(4),
    .SERVE_CYCLES(8),
    .MAX_WAIT(20),
    .WAIT_W(5)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .det_a_raw(det_a_raw),
    .det_b_raw(det_b_raw),
    .light_x(light_x),
    .light_y(light_y),
    .light_z(light_z),
    .req_a(req_a),
    .req_b(req_b),
    .wait_alarm_a(wait_alarm_a),
    .wait_alarm_b(wait_alarm_b),
    .light_fault(light_fault)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  initial begin
    rstb = 1'b0;
    det_a_raw = 1'b0;
    det_b_raw = 1'b0;
    light_x = 1'b0;
    light_y = 1'b0;
    light_z = 1'b0;
    tick(3);
    chk("reset_outputs", {req_a, req_b, wait_alarm_a, wait_alarm_b, light_fault}, 5'b0);
    rstb = 1'b1;
    tick(2);
    light_y = 1'b1;
    tick(2);
    chk("mask_after_reset", {4'b0, light_fault}, 5'b0);
    det_a_raw = 1'b1;
    tick(6);
    chk("req_a_before_rise", {4'b0, req_a}, 5'b0);
    tick(1);
    chk("req_a_rise", {3'b0, req_a, req_b}, 5'b00010);
    det_a_raw = 1'b0;
    det_b_raw = 1'b1;
    tick(3);
    det_b_raw = 1'b0;
    tick(5);
    chk("glitch_b_1", {4'b0, req_b}, 5'b0);
    light_x = 1'b1;
    light_y = 1'b0;
    tick(7);
    chk("serve_a_7th", {4'b0, req_a}, 5'b1);
    tick(1);
    chk("serve_a_retire", {4'b0, req_a}, 5'b0);
    light_x = 1'b0;
    light_y = 1'b1;
    det_a_raw = 1'b1;
    tick(7);
    chk("req_a_rise2", {4'b0, req_a}, 5'b1);
    light_x = 1'b1;
    light_y = 1'b0;
    tick(8);
    chk("requeue_a", {4'b0, req_a}, 5'b1);
    det_a_raw = 1'b0;
    tick(5);
    light_x = 1'b0;
    light_y = 1'b1;
    tick(1);
    chk("partial_green_a", {4'b0, req_a}, 5'b1);
    det_b_raw = 1'b1;
    tick(3);
    det_b_raw = 1'b0;
    tick(5);
    chk("partial_hold_a", {3'b0, req_a, wait_alarm_a}, 5'b00010);
    light_x = 1'b1;
    light_y = 1'b0;
    tick(7);
    chk("partial_then_7", {4'b0, req_a}, 5'b1);
    tick(1);
    chk("partial_then_retire", {3'b0, req_a, req_b}, 5'b0);
    light_x = 1'b0;
    light_y = 1'b1;
    det_b_raw = 1'b1;
    tick(7);
    chk("req_b_rise", {3'b0, req_b, req_a}, 5'b00010);
    det_b_raw = 1'b0;
    tick(19);
    chk("alarm_b_before", {4'b0, wait_alarm_b}, 5'b0);
    tick(1);
    chk("alarm_b_rise", {3'b0, wait_alarm_b, wait_alarm_a}, 5'b00010);
    tick(3);
    chk("alarm_b_hold", {4'b0, wait_alarm_b}, 5'b1);
    light_z = 1'b1;
    light_y = 1'b0;
    tick(1);
    chk("alarm_b_clear", {3'b0, wait_alarm_b, req_b}, 5'b00001);
    tick(7);
    chk("serve_b_retire", {3'b0, req_b, light_fault}, 5'b0);
    light_z = 1'b0;
    light_y = 1'b1;
    tick(2);
    light_x = 1'b1;
    light_z = 1'b1;
    light_y = 1'b0;
    tick(1);
    chk("fault_set", {4'b0, light_fault}, 5'b1);
    light_x = 1'b0;
    light_z = 1'b0;
    light_y = 1'b1;
    tick(3);
    chk("fault_sticky", {4'b0, light_fault}, 5'b1);
    det_a_raw = 1'b1;
    tick(7);
    chk("req_a_rise3", {4'b0, req_a}, 5'b1);
    light_x = 1'b1;
    light_y = 1'b0;
    tick(3);
    rstb = 1'b0;
    tick(1);
    chk("reset_mid_serving", {req_a, req_b, wait_alarm_a, wait_alarm_b, light_fault}, 5'b0);
    rstb = 1'b1;
    det_a_raw = 1'b0;
    light_x = 1'b0;
    light_y = 1'b1;
    tick(10);
    chk("no_residual", {req_a, req_b, wait_alarm_a, wait_alarm_b, light_fault}, 5'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
